alu_issue_stage: RTL and testbench

Operand-fetch and issue stage sitting directly upstream of the combinational 8-bit ALU. It accepts decoded instructions from the decoder over a valid/ready handshake and reads two operands from an internal register file. It registers A/B/OP into an execute (E) pipeline register that drives the ALU, then writes the ALU result and Zero/Sign flags back at the end of the E cycle.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_regfile.sv | 47 ++++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcode encoding and the
// decoded-instruction bundle presented by the decoder.
package alu_pkg;

  localparam int W    = 8;
  localparam int OPS  = 3;
  localparam int NREG = 8;
  localparam int RA   = $clog2(NREG);

  typedef enum logic [OPS-1:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_XOR = 3'b011
  } alu_op_e;

  typedef struct packed {
    alu_op_e         op;
    logic [RA-1:0]   ra;
    logic [RA-1:0]   rb;
    logic [RA-1:0]   rd;
    logic            imm_en;
    logic [W-1:0]    imm;
  } issue_instr_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two combinational operand reads, one combinational
// debug read, one synchronous write port, asynchronous active-low clear.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [RA-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [RA-1:0] raddr_a_i,
  input  logic [RA-1:0] raddr_b_i,
  input  logic [RA-1:0] raddr_dbg_i,
  output logic [W-1:0]  rdata_a_o,
  output logic [W-1:0]  rdata_b_o,
  output logic [W-1:0]  rdata_dbg_o
);

  logic [W-1:0] mem_q [NREG];
  logic [W-1:0] mem_d [NREG];

  // Next-state of the storage array: a single entry updated on write.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue stage feeding a combinational ALU, with one-cycle writeback.
// Optional operand forwarding from the E stage is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPS-1:0] in_op,
  input  logic [RA-1:0]  in_ra,
  input  logic [RA-1:0]  in_rb,
  input  logic [RA-1:0]  in_rd,
  input  logic           in_imm_en,
  input  logic [W-1:0]   in_imm,
  input  logic           stall,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPS-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_sign,
  output logic           e_valid,
  output logic           zero_flag,
  output logic           sign_flag,
  input  logic [RA-1:0]  dbg_addr,
  output logic [W-1:0]   dbg_data
);

  issue_instr_t   instr_s;
  logic           e_valid_q, e_valid_d;
  logic [RA-1:0]  e_rd_q, e_rd_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OPS-1:0] alu_op_q, alu_op_d;
  logic           zero_q, zero_d, sign_q, sign_d;
  logic [W-1:0]   rf_a_s, rf_b_s, src_a_s, src_b_s;
  logic           hazard_s, in_ready_s, transfer_s, wb_en_s;

  assign instr_s = '{op: alu_op_e'(in_op), ra: in_ra, rb: in_rb, rd: in_rd,
                     imm_en: in_imm_en, imm: in_imm};

  assign wb_en_s = e_valid_q & ~stall;

  alu_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (wb_en_s),
    .waddr_i     (e_rd_q),
    .wdata_i     (alu_out),
    .raddr_a_i   (instr_s.ra),
    .raddr_b_i   (instr_s.rb),
    .raddr_dbg_i (dbg_addr),
    .rdata_a_o   (rf_a_s),
    .rdata_b_o   (rf_b_s),
    .rdata_dbg_o (dbg_data)
  );

`ifdef ALU_ISSUE_FWD_EN
  // The E-stage result is the value written back at this same edge, so it can be used directly.
  assign src_a_s  = (e_valid_q && (instr_s.ra == e_rd_q)) ? alu_out : rf_a_s;
  assign src_b_s  = (e_valid_q && (instr_s.rb == e_rd_q)) ? alu_out : rf_b_s;
  assign hazard_s = 1'b0;
`else
  assign src_a_s  = rf_a_s;
  assign src_b_s  = rf_b_s;
  assign hazard_s = e_valid_q & ((instr_s.ra == e_rd_q) |
                                 (~instr_s.imm_en & (instr_s.rb == e_rd_q)));
`endif

  assign in_ready_s = ~stall & ~hazard_s;
  assign transfer_s = in_valid & in_ready_s;

  // E-stage and flag next-state: hold on stall, load on transfer, otherwise empty.
  always_comb begin
    e_valid_d = e_valid_q;
    e_rd_d    = e_rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    if (stall) begin
      e_valid_d = e_valid_q;
    end else if (transfer_s) begin
      e_valid_d = 1'b1;
      e_rd_d    = instr_s.rd;
      alu_a_d   = src_a_s;
      alu_b_d   = instr_s.imm_en ? instr_s.imm : src_b_s;
      alu_op_d  = instr_s.op;
    end else begin
      e_valid_d = 1'b0;
    end
    if (wb_en_s) begin
      zero_d = alu_zero;
      sign_d = alu_sign;
    end else begin
      zero_d = zero_q;
      sign_d = sign_q;
    end
  end

  // E pipeline register and writeback flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_rd_q    <= {RA{1'b0}};
      alu_a_q   <= {W{1'b0}};
      alu_b_q   <= {W{1'b0}};
      alu_op_q  <= {OPS{1'b0}};
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      zero_q    <= zero_d;
      sign_q    <= sign_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign e_valid   = e_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign zero_flag = zero_q;
  assign sign_flag = sign_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a behavioural ALU closes the loop, an
// architectural register model predicts every writeback.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic       clk, rst_n, in_valid, in_ready, in_imm_en, stall;
  logic [2:0] in_op, in_ra, in_rb, in_rd, alu_op, dbg_addr;
  logic [7:0] in_imm, alu_a, alu_b, alu_out, dbg_data;
  logic       alu_zero, alu_sign, e_valid, zero_flag, sign_flag;

  typedef struct {
    logic [7:0] a, b, res;
    logic [2:0] op, rd;
    logic       z, s;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       pend;
  logic [7:0] m_regs [8];
  int         n_tests = 0, n_fail = 0;
  bit         rand_mode = 0, done = 0, final_swept = 0, timeout_flag = 0;
  bit         rst_swept = 0, chk_pending = 0;
  logic       m_e_valid;
  logic [2:0] m_e_rd, m_op;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_imm_en(in_imm_en), .in_imm(in_imm), .stall(stall),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .e_valid(e_valid),
    .zero_flag(zero_flag), .sign_flag(sign_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [7:0] ref_alu(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a >> b[2:0];
      3'd2:    return a << b[2:0];
      3'd3:    return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out  = ref_alu(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_out == 8'h00);
  assign alu_sign = alu_out[7];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Acceptance rule: stall blocks; without forwarding a read of the in-flight destination waits.
  function automatic logic exp_ready();
`ifdef ALU_ISSUE_FWD_EN
    return !stall;
`else
    return !stall && !(m_e_valid && (in_ra == m_e_rd || (!in_imm_en && in_rb == m_e_rd)));
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e_valid <= 1'b0; m_e_rd <= 3'd0; m_op <= 3'd0;
    end else if (!stall) begin
      m_e_valid <= in_valid && exp_ready();
      if (in_valid && exp_ready()) begin
        m_e_rd <= in_rd; m_op <= in_op;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: checks reset state, handshake, and pops the scoreboard at each writeback.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_pending = 0;
      if (!rst_swept) begin
        chk("rst_e_valid", e_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_sign", sign_flag, 0);
        chk("rst_in_ready", in_ready, !stall);
        for (int a = 0; a < 8; a++) begin
          dbg_addr = a[2:0];
          #1 chk("rst_dbg", dbg_data, 0);
        end
        rst_swept = 1;
      end
    end else begin
      rst_swept = 0;
      if (chk_pending) begin
        chk("wb_zero", zero_flag, pend.z);
        chk("wb_sign", sign_flag, pend.s);
        chk("wb_reg", dbg_data, pend.res);
        chk_pending = 0;
      end
      chk("e_valid", e_valid, m_e_valid);
      chk("in_ready", in_ready, exp_ready());
      if (!e_valid) chk("alu_op_hold", alu_op, m_op);
      if (e_valid && !stall) begin
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          pend = sb_q.pop_front();
          chk("alu_a", alu_a, pend.a);
          chk("alu_b", alu_b, pend.b);
          chk("alu_op", alu_op, pend.op);
          dbg_addr = pend.rd;
          chk_pending = 1;
        end
      end
      if (done && !final_swept) begin
        chk("sb_drained", sb_q.size(), 0);
        chk("no_timeout", timeout_flag, 0);
        for (int a = 0; a < 8; a++) begin
          dbg_addr = a[2:0];
          #1 chk("final_reg", dbg_data, m_regs[a]);
        end
        final_swept = 1;
      end
    end
  end

  function automatic logic pick_stall();
    return rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd, input logic ie, input logic [7:0] imm);
    bit   acc;
    int   waitc;
    exp_t e;
    #1;
    in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
    in_imm_en = ie; in_imm = imm; stall = pick_stall();
    acc = 0; waitc = 0;
    while (!acc && waitc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (!acc) begin
        waitc++;
        #1 stall = pick_stall();
      end
    end
    if (acc) begin
      e.a = m_regs[ra];
      e.b = ie ? imm : m_regs[rb];
      e.op = op; e.rd = rd;
      e.res = ref_alu(op, e.a, e.b);
      e.z = (e.res == 8'h00); e.s = e.res[7];
      m_regs[rd] = e.res;
      sb_q.push_back(e);
    end else begin
      timeout_flag = 1;
    end
  endtask

  task automatic idle(input int n);
    #1 in_valid = 1'b0; stall = pick_stall();
    repeat (n) @(posedge clk);
  endtask

  task automatic hold_stall(input int n);
    #1 in_valid = 1'b0; stall = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; stall = 1'b0; in_op = 3'd0; in_ra = 3'd0;
    in_rb = 3'd0; in_rd = 3'd0; in_imm_en = 1'b0; in_imm = 8'h00;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    #5 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    issue(3'd0, 3'd1, 3'd0, 3'd1, 1'b1, 8'h05);   // r1 = r1 + 5
    issue(3'd0, 3'd1, 3'd0, 3'd2, 1'b1, 8'h03);   // r2 = r1 + 3
    issue(3'd3, 3'd2, 3'd0, 3'd3, 1'b1, 8'h08);   // r3 = r2 ^ 8 -> 0
    issue(3'd2, 3'd1, 3'd0, 3'd4, 1'b1, 8'h01);   // r4 = r1 << 1
    hold_stall(3);
    idle(2);
    issue(3'd3, 3'd1, 3'd4, 3'd6, 1'b0, 8'h00);   // r6 = r1 ^ r4
    issue(3'd1, 3'd6, 3'd0, 3'd7, 1'b1, 8'h02);   // r7 = r6 >> 2
    issue(3'd0, 3'd0, 3'd0, 3'd5, 1'b1, 8'hFF);   // r5 = 0xFF
    issue(3'd0, 3'd5, 3'd0, 3'd5, 1'b1, 8'h01);   // r5 wraps to 0
    idle(2);
    issue(3'd0, 3'd1, 3'd0, 3'd7, 1'b1, 8'h10);   // discarded by reset
    #1 rst_n = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    rand_mode = 1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    rand_mode = 0;
    idle(4);
    done = 1;
    repeat (3) @(posedge clk);
    if (!final_swept) begin
      $display("FAIL final_sweep: not reached");
      $fatal(1, "final sweep missing");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
